// File: rtl/axi_id_remap_rd_ctrl.sv
// Read-path controller for the AXI ID remapper: narrows AR IDs through the
// external ID generator table and restores the wide ID on returning R beats.
module axi_id_remap_rd_ctrl #(
   parameter int ID_WIDTH_IN  = 8,
   parameter int ID_WIDTH_OUT = 6,
   parameter int AR_PLD_WIDTH = 61,
   parameter int R_PLD_WIDTH  = 67,
   parameter int MAX_OUTST    = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // slave AR
   input  logic                    s_ar_valid,
   output logic                    s_ar_ready,
   input  logic [ID_WIDTH_IN-1:0]  s_ar_id,
   input  logic [AR_PLD_WIDTH-1:0] s_ar_pld,
   // master AR
   output logic                    m_ar_valid,
   input  logic                    m_ar_ready,
   output logic [ID_WIDTH_OUT-1:0] m_ar_id,
   output logic [AR_PLD_WIDTH-1:0] m_ar_pld,
   // master R
   input  logic                    m_r_valid,
   output logic                    m_r_ready,
   input  logic [ID_WIDTH_OUT-1:0] m_r_id,
   input  logic                    m_r_last,
   input  logic [R_PLD_WIDTH-1:0]  m_r_pld,
   // slave R
   output logic                    s_r_valid,
   input  logic                    s_r_ready,
   output logic [ID_WIDTH_IN-1:0]  s_r_id,
   output logic                    s_r_last,
   output logic [R_PLD_WIDTH-1:0]  s_r_pld,
   // ID generator
   output logic                    gen_incr_o,
   output logic [ID_WIDTH_IN-1:0]  gen_id_o,
   input  logic [ID_WIDTH_OUT-1:0] gen_id_i,
   input  logic                    gen_full_i,
   output logic                    gen_rel_o,
   output logic [ID_WIDTH_OUT-1:0] gen_bid_o,
   input  logic [ID_WIDTH_IN-1:0]  gen_bid_i,
   input  logic                    gen_empty_i,
   // drain control and status
   input  logic                    drain_i,
   output logic                    drained_o,
   output logic                    err_o
);

   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAINING,
      ST_DRAINED
   } state_t;

   state_t           state, state_next;
   logic             run_en;
   logic [CNT_W-1:0] outst_cnt, outst_cnt_next;
   logic             accept;
   logic             release_beat;
   logic             release_bad;
   logic             release_ok;
   logic             m_ar_valid_next;
   logic             err_next;
   logic             idle_next;

   // run_en keeps s_ar_ready low while in reset and re-enables it on the first edge after
   assign s_ar_ready = run_en & (state == ST_RUN) & ~drain_i & ~gen_full_i
                       & (~m_ar_valid | m_ar_ready);
   assign accept     = s_ar_valid & s_ar_ready;
   assign gen_incr_o = accept;
   assign gen_id_o   = s_ar_id;

   assign s_r_valid = m_r_valid;
   assign m_r_ready = s_r_ready;
   assign s_r_last  = m_r_last;
   assign s_r_pld   = m_r_pld;
   assign gen_bid_o = m_r_id;
   assign s_r_id    = gen_bid_i;

   assign release_beat = m_r_valid & s_r_ready & m_r_last;
   assign gen_rel_o    = release_beat;
   assign release_bad  = release_beat & (outst_cnt == '0);
   assign release_ok   = release_beat & ~release_bad;

   // A release with nothing outstanding is an error and must not underflow the count
   always_comb begin
      outst_cnt_next = outst_cnt;
      if (accept && !release_ok) begin
         outst_cnt_next = outst_cnt + CNT_W'(1);
      end else if (!accept && release_ok) begin
         outst_cnt_next = outst_cnt - CNT_W'(1);
      end
   end

   assign m_ar_valid_next = accept | (m_ar_valid & ~m_ar_ready);
   assign idle_next       = ~m_ar_valid_next & (outst_cnt_next == '0) & gen_empty_i;
   assign err_next        = err_o | release_bad
                            | ((outst_cnt == '0) & ~gen_empty_i & ~release_beat);

   always_comb begin
      state_next = state;
      unique case (state)
         ST_RUN: begin
            if (drain_i) state_next = ST_DRAINING;
         end
         ST_DRAINING: begin
            if (!drain_i)       state_next = ST_RUN;
            else if (idle_next) state_next = ST_DRAINED;
         end
         ST_DRAINED: begin
            if (!drain_i) state_next = ST_RUN;
         end
         default: state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         run_en    <= 1'b0;
         outst_cnt <= '0;
         drained_o <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         state     <= state_next;
         run_en    <= 1'b1;
         outst_cnt <= outst_cnt_next;
         drained_o <= (state_next == ST_DRAINED);
         err_o     <= err_next;
      end
   end

   // Output register holds id/payload stable until the master accepts it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ar_valid <= 1'b0;
         m_ar_id    <= '0;
         m_ar_pld   <= '0;
      end else begin
         m_ar_valid <= m_ar_valid_next;
         if (accept) begin
            m_ar_id  <= gen_id_i;
            m_ar_pld <= s_ar_pld;
         end
      end
   end

endmodule

// File: tb/tb_axi_id_remap_rd_ctrl.sv
// Self-checking bench for axi_id_remap_rd_ctrl with a 4-entry generator model
// and a transaction-level reference model compared every cycle.
module tb_axi_id_remap_rd_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_ar_valid = 1'b0;
   logic        s_ar_ready;
   logic [7:0]  s_ar_id = '0;
   logic [60:0] s_ar_pld = '0;
   logic        m_ar_valid;
   logic        m_ar_ready = 1'b0;
   logic [5:0]  m_ar_id;
   logic [60:0] m_ar_pld;
   logic        m_r_valid = 1'b0;
   logic        m_r_ready;
   logic [5:0]  m_r_id = '0;
   logic        m_r_last = 1'b0;
   logic [66:0] m_r_pld = '0;
   logic        s_r_valid;
   logic        s_r_ready = 1'b1;
   logic [7:0]  s_r_id;
   logic        s_r_last;
   logic [66:0] s_r_pld;
   logic        gen_incr_o;
   logic [7:0]  gen_id_o;
   logic [5:0]  gen_id_i;
   logic        gen_full_i;
   logic        gen_rel_o;
   logic [5:0]  gen_bid_o;
   logic [7:0]  gen_bid_i;
   logic        gen_empty_i;
   logic        drain_i = 1'b0;
   logic        drained_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_id_remap_rd_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_pld(s_ar_pld),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id), .m_ar_pld(m_ar_pld),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_last(m_r_last),
      .m_r_pld(m_r_pld),
      .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_last(s_r_last),
      .s_r_pld(s_r_pld),
      .gen_incr_o(gen_incr_o), .gen_id_o(gen_id_o), .gen_id_i(gen_id_i), .gen_full_i(gen_full_i),
      .gen_rel_o(gen_rel_o), .gen_bid_o(gen_bid_o), .gen_bid_i(gen_bid_i),
      .gen_empty_i(gen_empty_i),
      .drain_i(drain_i), .drained_o(drained_o), .err_o(err_o)
   );

   // Generator environment: lowest free slot is offered, table updated on strobes
   logic       gv [4];
   logic [7:0] gw [4];

   always_comb begin
      gen_id_i    = '0;
      gen_full_i  = 1'b1;
      gen_empty_i = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         if (!gv[i]) begin
            gen_id_i   = 6'(i);
            gen_full_i = 1'b0;
         end else begin
            gen_empty_i = 1'b0;
         end
      end
      gen_bid_i = gw[gen_bid_o[1:0]];
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            gv[i] <= 1'b0;
            gw[i] <= '0;
         end
      end else begin
         if (gen_rel_o) gv[gen_bid_o[1:0]] <= 1'b0;
         if (gen_incr_o) begin
            gv[gen_id_i[1:0]] <= 1'b1;
            gw[gen_id_i[1:0]] <= gen_id_o;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one pending AR slot, burst count, sticky error, accept-enable
   logic        mdl_mv, mdl_err, mdl_run;
   logic [5:0]  mdl_id;
   logic [60:0] mdl_pld;
   int          mdl_cnt;

   always @(negedge clk) begin
      logic exp_rdy, hs, rel;
      if (!rst_n) begin
         checkOutput("rst_s_ar_ready", s_ar_ready, 0);
         checkOutput("rst_m_ar_valid", m_ar_valid, 0);
         checkOutput("rst_m_ar_id", m_ar_id, 0);
         checkOutput("rst_err", err_o, 0);
         checkOutput("rst_drained", drained_o, 0);
         mdl_mv = 0; mdl_id = '0; mdl_pld = '0; mdl_cnt = 0; mdl_err = 0; mdl_run = 0;
      end else begin
         exp_rdy = mdl_run && !drain_i && !gen_full_i && (!mdl_mv || m_ar_ready);
         hs      = s_ar_valid && exp_rdy;
         rel     = m_r_valid && s_r_ready && m_r_last;
         checkOutput("s_ar_ready", s_ar_ready, exp_rdy);
         checkOutput("gen_incr", gen_incr_o, hs);
         checkOutput("m_ar_valid", m_ar_valid, mdl_mv);
         if (mdl_mv) begin
            checkOutput("m_ar_id", m_ar_id, mdl_id);
            checkOutput("m_ar_pld", m_ar_pld, mdl_pld);
         end
         checkOutput("s_r_valid", s_r_valid, m_r_valid);
         checkOutput("m_r_ready", m_r_ready, s_r_ready);
         checkOutput("s_r_last", s_r_last, m_r_last);
         checkOutput("s_r_pld", s_r_pld, m_r_pld);
         checkOutput("s_r_id", s_r_id, gw[m_r_id[1:0]]);
         checkOutput("gen_rel", gen_rel_o, rel);
         checkOutput("err", err_o, mdl_err);
         if (rel && mdl_cnt == 0) mdl_err = 1;
         if (hs) begin
            mdl_mv = 1; mdl_id = gen_id_i; mdl_pld = s_ar_pld;
         end else if (m_ar_ready) begin
            mdl_mv = 0;
         end
         mdl_cnt = mdl_cnt + (hs ? 1 : 0) - ((rel && mdl_cnt > 0) ? 1 : 0);
         mdl_run = !drain_i;
      end
   end

   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic rlast(input logic [5:0] id, input logic [7:0] exp_wide);
      m_r_valid = 1; m_r_last = 1; m_r_id = id; m_r_pld = 67'(id) + 67'h100;
      @(negedge clk);
      checkOutput("rlast_s_r_id", s_r_id, exp_wide);
      checkOutput("rlast_rel", gen_rel_o, 1);
      applyStimulus();
      m_r_valid = 0; m_r_last = 0;
   endtask

   initial begin
      int incr_cnt, idx, cyc, beat, rel_cnt, rel_beat;
      int acc_cyc [5];
      logic seen;

      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      applyStimulus();

      // Single AR with master stalled for 3 cycles
      s_ar_valid = 1; s_ar_id = 8'hA5; s_ar_pld = 61'h1_2345_6789;
      @(negedge clk);
      checkOutput("first_accept", gen_incr_o, 1);
      incr_cnt = 1;
      applyStimulus();
      s_ar_id = 8'h3C; s_ar_pld = 61'h0_0BAD_CAFE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("stall_valid", m_ar_valid, 1);
         checkOutput("stall_id", m_ar_id, 0);
         checkOutput("stall_pld", m_ar_pld, 61'h1_2345_6789);
         checkOutput("stall_ready", s_ar_ready, 0);
         if (gen_incr_o) incr_cnt++;
         applyStimulus();
      end
      checkOutput("stall_incr_count", incr_cnt, 1);
      m_ar_ready = 1;
      @(negedge clk);
      checkOutput("unstall_accept", gen_incr_o, 1);
      applyStimulus();
      s_ar_valid = 0;
      @(negedge clk);
      checkOutput("second_id", m_ar_id, 1);
      applyStimulus();
      rlast(6'd0, 8'hA5);
      rlast(6'd1, 8'h3C);

      // Five back-to-back ARs: fifth waits for the release in cycle 7
      idx = 0; cyc = 0;
      while (idx < 5 && cyc < 20) begin
         s_ar_valid = 1; s_ar_id = 8'h10 + 8'(idx); s_ar_pld = 61'(idx) + 61'h700;
         m_r_valid = (cyc == 7); m_r_last = (cyc == 7); m_r_id = 6'd2;
         @(negedge clk);
         if (s_ar_ready) begin
            acc_cyc[idx] = cyc;
            idx++;
         end
         applyStimulus();
         cyc++;
      end
      s_ar_valid = 0; m_r_valid = 0; m_r_last = 0;
      checkOutput("b2b_count", idx, 5);
      checkOutput("b2b_acc0", acc_cyc[0], 0);
      checkOutput("b2b_acc3", acc_cyc[3], 3);
      checkOutput("b2b_acc4", acc_cyc[4], 8);
      @(negedge clk);
      checkOutput("b2b_reuse_id", m_ar_id, 2);
      applyStimulus();

      // Four-beat burst on narrow id 0 with s_r_ready toggling
      beat = 0; cyc = 0; rel_cnt = 0; rel_beat = -1;
      while (beat < 4 && cyc < 20) begin
         m_r_valid = 1; m_r_id = 0; m_r_last = (beat == 3); m_r_pld = 67'(beat);
         s_r_ready = (cyc % 2 == 0);
         @(negedge clk);
         if (gen_rel_o) begin
            rel_cnt++;
            rel_beat = beat;
         end
         if (s_r_ready) begin
            checkOutput("burst_s_r_id", s_r_id, 8'h10);
            beat++;
         end
         applyStimulus();
         cyc++;
      end
      m_r_valid = 0; m_r_last = 0; s_r_ready = 1;
      checkOutput("burst_rel_count", rel_cnt, 1);
      checkOutput("burst_rel_beat", rel_beat, 3);

      // Drain with two bursts outstanding (narrow 3 and 2)
      rlast(6'd1, 8'h11);
      drain_i = 1; s_ar_valid = 1; s_ar_id = 8'h55; s_ar_pld = 61'h55;
      @(negedge clk);
      checkOutput("drain_block", s_ar_ready, 0);
      applyStimulus();
      @(negedge clk);
      checkOutput("drain_not_done", drained_o, 0);
      applyStimulus();
      rlast(6'd3, 8'h13);
      @(negedge clk);
      checkOutput("drain_one_left", drained_o, 0);
      applyStimulus();
      rlast(6'd2, 8'h14);
      seen = 0;
      for (int i = 0; i < 5 && !seen; i++) begin
         @(negedge clk);
         if (drained_o) seen = 1;
         else applyStimulus();
      end
      checkOutput("drained", seen, 1);
      applyStimulus();
      drain_i = 0;
      @(negedge clk);
      checkOutput("drained_hold", drained_o, 1);
      applyStimulus();
      @(negedge clk);
      checkOutput("undrain_clear", drained_o, 0);
      checkOutput("undrain_accept", gen_incr_o, 1);
      applyStimulus();
      s_ar_valid = 0;
      rlast(6'd0, 8'h55);

      // Release with nothing outstanding
      m_r_valid = 1; m_r_last = 1; m_r_id = 0;
      @(negedge clk);
      checkOutput("err_before", err_o, 0);
      applyStimulus();
      m_r_valid = 0; m_r_last = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("err_sticky", err_o, 1);
         applyStimulus();
      end
      rst_n = 0;
      #1 checkOutput("err_cleared", err_o, 0);
      applyStimulus();
      applyStimulus();
      rst_n = 1;
      repeat (3) applyStimulus();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
